// File: rtl/vend_pkg.sv
// Shared vending definitions: FSM states, coin denominations and the price table
// consumed by the vending FSM.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } state_e;

  localparam int NUM_COINS = 6;

  // Index equals the bit position in the one-hot eject command.
  localparam int COIN_1   = 0;
  localparam int COIN_5   = 1;
  localparam int COIN_10  = 2;
  localparam int COIN_25  = 3;
  localparam int COIN_100 = 4;
  localparam int COIN_500 = 5;

  localparam logic [15:0] VAL_1   = 16'd1;
  localparam logic [15:0] VAL_5   = 16'd5;
  localparam logic [15:0] VAL_10  = 16'd10;
  localparam logic [15:0] VAL_25  = 16'd25;
  localparam logic [15:0] VAL_100 = 16'd100;
  localparam logic [15:0] VAL_500 = 16'd500;

  localparam logic [15:0] PRICE_TABLE [16] = '{
    16'd50,  16'd65,  16'd75,  16'd90,  16'd100, 16'd115, 16'd125, 16'd135,
    16'd150, 16'd165, 16'd175, 16'd200, 16'd225, 16'd250, 16'd275, 16'd300
  };

  function automatic logic [15:0] coin_value(input int idx);
    logic [15:0] v;
    case (idx)
      COIN_500: v = VAL_500;
      COIN_100: v = VAL_100;
      COIN_25:  v = VAL_25;
      COIN_10:  v = VAL_10;
      COIN_5:   v = VAL_5;
      COIN_1:   v = VAL_1;
      default:  v = 16'd0;
    endcase
    return v;
  endfunction

  function automatic logic [15:0] onehot_value(input logic [5:0] oh);
    logic [15:0] v;
    v = 16'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (oh[i]) v = v | coin_value(i);
    end
    return v;
  endfunction

endpackage

// File: rtl/coin_picker.sv
// Greedy coin selector: highest denomination that fits the remaining amount
// and whose hopper is not empty.
module coin_picker
  import vend_pkg::*;
(
  input  logic [15:0] remain,
  input  logic [5:0]  nonempty,
  output logic [5:0]  sel,
  output logic        found
);

  always_comb begin
    sel   = 6'd0;
    found = 1'b0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (!found && nonempty[i] && (coin_value(i) <= remain)) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Change payout sequencer: greedily ejects coins over a req/ack handshake,
// tracks hopper inventory and reports done, shortfall or hopper fault.
module change_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned COIN_INIT   = 20,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_REQ_VALID,
  input  logic [15:0] I_REQ_AMOUNT,
  output logic        O_REQ_READY,
  output logic [5:0]  O_EJECT,
  input  logic        I_EJECT_ACK,
  input  logic        I_REFILL,
  output logic        O_DONE,
  output logic        O_SHORT,
  output logic [15:0] O_REMAIN,
  output logic        O_BUSY,
  output logic        O_FAULT,
  output logic [2:0]  O_DBG_STATE
);

  // Handshakes: a request transfers on a cycle where I_REQ_VALID and O_REQ_READY
  // are both high. O_EJECT stays constant until the cycle I_EJECT_ACK is seen high
  // (one coin per ack) or the ack timeout expires.
  localparam logic [7:0] INIT_CNT = 8'(COIN_INIT);
  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] remain_q, remain_d;
  logic [5:0]  eject_q, eject_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        short_q, short_d;
  logic        fault_q, fault_d;
  logic [7:0]  count_q [NUM_COINS];
  logic [7:0]  count_d [NUM_COINS];

  logic [5:0]  nonempty;
  logic [5:0]  pick_sel;
  logic        pick_found;

  always_comb begin
    nonempty = 6'd0;
    for (int i = 0; i < NUM_COINS; i++) begin
      nonempty[i] = (count_q[i] != 8'd0);
    end
  end

  coin_picker u_picker (
    .remain   (remain_q),
    .nonempty (nonempty),
    .sel      (pick_sel),
    .found    (pick_found)
  );

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    eject_d  = eject_q;
    tmo_d    = tmo_q;
    short_d  = short_q;
    fault_d  = fault_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (I_REFILL) begin
          for (int i = 0; i < NUM_COINS; i++) count_d[i] = INIT_CNT;
        end
        if (I_REQ_VALID && !fault_q) begin
          remain_d = I_REQ_AMOUNT;
          short_d  = 1'b0;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (remain_q == 16'd0) begin
          short_d = 1'b0;
          state_d = ST_DONE;
        end else if (pick_found) begin
          eject_d = pick_sel;
          tmo_d   = 8'd0;
          state_d = ST_EJECT;
        end else begin
          short_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (I_EJECT_ACK) begin
          // The picker only offers a coin whose value fits, so no underflow here.
          remain_d = remain_q - onehot_value(eject_q);
          for (int i = 0; i < NUM_COINS; i++) begin
            if (eject_q[i] && count_q[i] != 8'd0) count_d[i] = count_q[i] - 8'd1;
          end
          eject_d = 6'd0;
          tmo_d   = 8'd0;
          state_d = ST_SELECT;
        end else if (tmo_q == TMO_LAST) begin
          eject_d = 6'd0;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q  <= ST_IDLE;
      remain_q <= 16'd0;
      eject_q  <= 6'd0;
      tmo_q    <= 8'd0;
      short_q  <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < NUM_COINS; i++) count_q[i] <= INIT_CNT;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      eject_q  <= eject_d;
      tmo_q    <= tmo_d;
      short_q  <= short_d;
      fault_q  <= fault_d;
      for (int i = 0; i < NUM_COINS; i++) count_q[i] <= count_d[i];
    end
  end

  assign O_REQ_READY = (state_q == ST_IDLE) && !fault_q;
  assign O_EJECT     = eject_q;
  assign O_DONE      = (state_q == ST_DONE);
  assign O_SHORT     = (state_q == ST_DONE) && short_q;
  assign O_REMAIN    = remain_q;
  assign O_BUSY      = (state_q != ST_IDLE);
  assign O_FAULT     = fault_q;
  assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: two instances (20-coin and 1-coin hoppers),
// directed requests, eject/done events checked against an expected queue.
module tb_change_dispense_ctrl;
  import vend_pkg::*;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance A: COIN_INIT=20, ACK_TIMEOUT=8
  logic        a_rst, a_valid, a_ack, a_refill;
  logic [15:0] a_amount;
  logic        a_ready, a_done, a_short, a_busy, a_fault;
  logic [5:0]  a_eject;
  logic [15:0] a_remain;
  logic [2:0]  a_state;

  // instance B: COIN_INIT=1, ACK_TIMEOUT=8
  logic        b_rst, b_valid, b_ack, b_refill;
  logic [15:0] b_amount;
  logic        b_ready, b_done, b_short, b_busy, b_fault;
  logic [5:0]  b_eject;
  logic [15:0] b_remain;
  logic [2:0]  b_state;

  change_dispense_ctrl #(.COIN_INIT(20), .ACK_TIMEOUT(8)) dut_a (
    .I_CLK(clk), .I_RESET(a_rst), .I_REQ_VALID(a_valid), .I_REQ_AMOUNT(a_amount),
    .O_REQ_READY(a_ready), .O_EJECT(a_eject), .I_EJECT_ACK(a_ack), .I_REFILL(a_refill),
    .O_DONE(a_done), .O_SHORT(a_short), .O_REMAIN(a_remain), .O_BUSY(a_busy),
    .O_FAULT(a_fault), .O_DBG_STATE(a_state)
  );

  change_dispense_ctrl #(.COIN_INIT(1), .ACK_TIMEOUT(8)) dut_b (
    .I_CLK(clk), .I_RESET(b_rst), .I_REQ_VALID(b_valid), .I_REQ_AMOUNT(b_amount),
    .O_REQ_READY(b_ready), .O_EJECT(b_eject), .I_EJECT_ACK(b_ack), .I_REFILL(b_refill),
    .O_DONE(b_done), .O_SHORT(b_short), .O_REMAIN(b_remain), .O_BUSY(b_busy),
    .O_FAULT(b_fault), .O_DBG_STATE(b_state)
  );

  int checks = 0;
  int failures = 0;
  logic [23:0] exp_a_q[$];
  logic [23:0] exp_b_q[$];
  bit ack_en_a = 1'b1;
  bit ack_en_b = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // event encoding: [23:22] kind (1 eject, 2 done), [16] short, [15:0] one-hot or remain
  function automatic logic [23:0] ev_ej(input int idx);
    logic [15:0] oh;
    oh = 16'd1 << idx;
    return {2'b01, 5'd0, 1'b0, oh};
  endfunction

  function automatic logic [23:0] ev_done(input logic sh, input logic [15:0] rem);
    return {2'b10, 5'd0, sh, rem};
  endfunction

  task automatic sb_pop(input int which, input logic [23:0] obs);
    logic [23:0] e;
    if (which == 0 ? exp_a_q.size() == 0 : exp_b_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_unexpected dut=%0d actual=%h expected=none", which, obs);
    end else begin
      e = (which == 0) ? exp_a_q.pop_front() : exp_b_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sb_event dut=%0d actual=%h expected=%h", which, obs, e);
      end
    end
  endtask

  // monitors: a new eject command (rising from zero) or a done pulse is an event
  logic [5:0] a_prev_ej = 6'd0;
  logic [5:0] b_prev_ej = 6'd0;
  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_eject != 6'd0 && a_prev_ej == 6'd0) sb_pop(0, {2'b01, 5'd0, 1'b0, 10'd0, a_eject});
      if (a_done) sb_pop(0, ev_done(a_short, a_remain));
    end
    a_prev_ej = a_eject;
  end
  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_eject != 6'd0 && b_prev_ej == 6'd0) sb_pop(1, {2'b01, 5'd0, 1'b0, 10'd0, b_eject});
      if (b_done) sb_pop(1, ev_done(b_short, b_remain));
    end
    b_prev_ej = b_eject;
  end

  // hopper models: ack arrives two cycles after the eject command is first seen
  int a_wait = 0;
  int b_wait = 0;
  always @(negedge clk) begin
    a_ack = 1'b0;
    if (ack_en_a && a_eject != 6'd0) begin
      if (a_wait == 2) begin a_ack = 1'b1; a_wait = 0; end
      else a_wait++;
    end else a_wait = 0;
  end
  always @(negedge clk) begin
    b_ack = 1'b0;
    if (ack_en_b && b_eject != 6'd0) begin
      if (b_wait == 2) begin b_ack = 1'b1; b_wait = 0; end
      else b_wait++;
    end else b_wait = 0;
  end

  task automatic send(input int which, input logic [15:0] amt, input logic refill);
    int n;
    n = 0;
    @(negedge clk);
    while ((which == 0 ? !a_ready : !b_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 32'(which == 0 ? a_ready : b_ready), 32'd1);
    if (which == 0) begin a_valid = 1'b1; a_amount = amt; a_refill = refill; end
    else begin b_valid = 1'b1; b_amount = amt; b_refill = refill; end
    @(negedge clk);
    a_valid = 1'b0; a_refill = 1'b0;
    b_valid = 1'b0; b_refill = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while ((which == 0 ? exp_a_q.size() : exp_b_q.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", (which == 0) ? exp_a_q.size() : exp_b_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_eject_a();
    int n;
    n = 0;
    while (a_eject == 6'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("eject_seen", 32'(a_eject != 6'd0), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    a_rst = 1'b1; a_valid = 1'b0; a_amount = 16'd0; a_refill = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_amount = 16'd0; b_refill = 1'b0;
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    // reset values
    check("rst_eject", 32'(a_eject), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_short", 32'(a_short), 32'd0);
    check("rst_remain", 32'(a_remain), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_fault", 32'(a_fault), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_state", 32'(a_state), 32'(ST_IDLE));
    for (int i = 0; i < NUM_COINS; i++) check("rst_count", 32'(dut_a.count_q[i]), 32'd20);

    // 275 cents: 100,100,25,25,25
    exp_a_q.push_back(ev_ej(COIN_100));
    exp_a_q.push_back(ev_ej(COIN_100));
    exp_a_q.push_back(ev_ej(COIN_25));
    exp_a_q.push_back(ev_ej(COIN_25));
    exp_a_q.push_back(ev_ej(COIN_25));
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd275, 1'b0);
    drain(0);
    check("cnt_100_after_275", 32'(dut_a.count_q[COIN_100]), 32'd18);
    check("cnt_25_after_275", 32'(dut_a.count_q[COIN_25]), 32'd17);

    // zero amount: done two cycles after acceptance, no eject
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd0, 1'b0);
    check("zero_done_c1", 32'(a_done), 32'd0);
    @(negedge clk);
    check("zero_done_c2", 32'(a_done), 32'd1);
    check("zero_short", 32'(a_short), 32'd0);
    drain(0);

    // reset in the middle of an eject
    ack_en_a = 1'b0;
    exp_a_q.push_back(ev_ej(COIN_100));
    send(0, 16'd275, 1'b0);
    wait_eject_a();
    @(negedge clk);
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("midrst_eject", 32'(a_eject), 32'd0);
    check("midrst_ready", 32'(a_ready), 32'd1);
    check("midrst_busy", 32'(a_busy), 32'd0);
    for (int i = 0; i < NUM_COINS; i++) check("midrst_count", 32'(dut_a.count_q[i]), 32'd20);
    check("midrst_sb", exp_a_q.size(), 0);

    // ack timeout: eject held 8 cycles, then sticky fault
    exp_a_q.push_back(ev_ej(COIN_100));
    send(0, 16'd100, 1'b0);
    wait_eject_a();
    cnt = 0;
    while (a_eject != 6'd0 && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("tmo_eject_cycles", cnt, 8);
    check("tmo_fault", 32'(a_fault), 32'd1);
    check("tmo_state", 32'(a_state), 32'(ST_FAULT));
    check("tmo_count_kept", 32'(dut_a.count_q[COIN_100]), 32'd20);
    a_valid = 1'b1; a_amount = 16'd5;
    repeat (5) @(negedge clk);
    check("fault_ready", 32'(a_ready), 32'd0);
    check("fault_busy", 32'(a_busy), 32'd1);
    check("fault_state", 32'(a_state), 32'(ST_FAULT));
    a_valid = 1'b0;
    a_rst = 1'b1;
    @(negedge clk);
    a_rst = 1'b0;
    check("fault_cleared", 32'(a_fault), 32'd0);
    check("fault_rst_ready", 32'(a_ready), 32'd1);
    ack_en_a = 1'b1;

    // deplete the 500 hopper
    for (int i = 0; i < 20; i++) exp_a_q.push_back(ev_ej(COIN_500));
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd10000, 1'b0);
    drain(0);
    check("cnt_500_empty", 32'(dut_a.count_q[COIN_500]), 32'd0);

    // empty 500 hopper is skipped
    for (int i = 0; i < 5; i++) exp_a_q.push_back(ev_ej(COIN_100));
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd500, 1'b0);
    drain(0);
    check("cnt_100_after_skip", 32'(dut_a.count_q[COIN_100]), 32'd15);

    // refill together with the request
    exp_a_q.push_back(ev_ej(COIN_500));
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd500, 1'b1);
    drain(0);
    check("refill_cnt_500", 32'(dut_a.count_q[COIN_500]), 32'd19);
    check("refill_cnt_100", 32'(dut_a.count_q[COIN_100]), 32'd20);

    // refill during EJECT is ignored
    exp_a_q.push_back(ev_ej(COIN_100));
    exp_a_q.push_back(ev_done(1'b0, 16'd0));
    send(0, 16'd100, 1'b0);
    wait_eject_a();
    a_refill = 1'b1;
    @(negedge clk);
    a_refill = 1'b0;
    drain(0);
    check("busy_refill_100", 32'(dut_a.count_q[COIN_100]), 32'd19);
    check("busy_refill_500", 32'(dut_a.count_q[COIN_500]), 32'd19);

    // single-coin hoppers: 30 -> 25,5; then 30 -> 10,1, short 19
    exp_b_q.push_back(ev_ej(COIN_25));
    exp_b_q.push_back(ev_ej(COIN_5));
    exp_b_q.push_back(ev_done(1'b0, 16'd0));
    send(1, 16'd30, 1'b0);
    drain(1);
    exp_b_q.push_back(ev_ej(COIN_10));
    exp_b_q.push_back(ev_ej(COIN_1));
    exp_b_q.push_back(ev_done(1'b1, 16'd19));
    send(1, 16'd30, 1'b0);
    drain(1);
    check("b_remain_held", 32'(b_remain), 32'd19);
    check("b_fault", 32'(b_fault), 32'd0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispense_ctrl.md
Name: change_dispense_ctrl

Overview:
Sequences the coin hopper that pays out change after a vend transaction.
- Accepts a change amount in cents from the vending FSM.
- Greedily ejects coins one at a time over a request/acknowledge handshake.
- Tracks per-denomination inventory and skips empty hoppers.
- Reports completion, shortfall or hopper fault back to the vending FSM.

Parameters:
- COIN_INIT, 20: initial and refill count per hopper; must be 1..255 (8-bit counters).
- ACK_TIMEOUT, 255: maximum cycles in EJECT waiting for I_EJECT_ACK before a fault; must be 1..255.

Ports:
- I_CLK  in  1  clock, rising edge.
- I_RESET  in  1  reset, synchronous, active-high.
- I_REQ_VALID  in  1  a change amount is offered.
- I_REQ_AMOUNT  in  16  change in cents, unsigned.
- O_REQ_READY  out  1  high only in IDLE with no fault.
- O_EJECT  out  6  one-hot eject command: bit5=500, bit4=100, bit3=25, bit2=10, bit1=5, bit0=1.
- I_EJECT_ACK  in  1  hopper confirms one coin ejected.
- I_REFILL  in  1  reload all counts to COIN_INIT; honoured in IDLE only.
- O_DONE  out  1  one-cycle pulse when a transaction ends.
- O_SHORT  out  1  valid with O_DONE; 1 means the amount was not fully paid.
- O_REMAIN  out  16  unpaid cents; held from O_DONE until the next request is accepted.
- O_BUSY  out  1  high in every state except IDLE.
- O_FAULT  out  1  sticky; set by a handshake timeout.

Behaviour:
- Reset values:
  - State IDLE.
  - O_EJECT=0, O_DONE=0, O_SHORT=0, O_REMAIN=0, O_BUSY=0, O_FAULT=0.
  - O_REQ_READY=1.
  - remain register=0, timeout counter=0.
  - All six counts=COIN_INIT.
- Reset takes priority over everything, including mid-EJECT.
  - The next cycle shows O_EJECT=0.
  - The partial payout is abandoned.
- State machine: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE:
  - Accept when I_REQ_VALID & O_REQ_READY: remain<=I_REQ_AMOUNT, go to SELECT.
  - I_REFILL in the same cycle also reloads the counts. The new counts are visible to SELECT.
- SELECT (1 cycle):
  - If remain==0: go to DONE with short=0.
  - Else pick the highest denomination d where value(d)<=remain and count[d]!=0, then go to EJECT with O_EJECT=onehot(d).
  - If no such d exists: go to DONE with short=1.
- EJECT:
  - O_EJECT is held constant and the timeout counter increments each cycle.
  - On I_EJECT_ACK=1:
    - remain<=remain-value(d); this cannot underflow because value(d)<=remain.
    - count[d]<=count[d]-1.
    - O_EJECT<=0, counter<=0, go to SELECT.
  - If the counter reaches ACK_TIMEOUT without an ack:
    - O_EJECT<=0, O_FAULT<=1, go to FAULT.
    - count[d] is unchanged.
- DONE (1 cycle):
  - O_DONE=1, O_SHORT=short, O_REMAIN=remain.
  - Go to IDLE.
- FAULT:
  - O_REQ_READY=0 and O_BUSY=1.
  - Only I_RESET leaves this state.
- Per-coin cost is 1 SELECT cycle plus at least 1 EJECT cycle, since the ack may arrive in the first EJECT cycle.
- An amount of 0 raises O_DONE 2 cycles after acceptance.
- The following inputs are ignored:
  - I_EJECT_ACK outside EJECT.
  - I_REQ_VALID while busy; the requester must hold it.
  - I_REFILL outside IDLE.
- Arithmetic: 16-bit unsigned remain; denomination values are 16-bit constants; 8-bit counts never decrement below 0.

Decomposition:
- Shared package vend_pkg holds:
  - The state enum.
  - Denomination index constants (COIN_500..COIN_1).
  - Denomination value constants.
  - The 16-entry price table used by the vending FSM.
- One sub-module: coin_picker.
  - Combinational priority selector.
  - Inputs: remain and six non-empty flags.
  - Outputs: one-hot select and a found flag.

Test Plan:
- 275 cents, ack 2 cycles after each eject:
  - Eject sequence is 100,100,25,25,25.
  - O_DONE with O_SHORT=0, O_REMAIN=0.
  - Final counts: 100-hopper 18, 25-hopper 17.
- 0 cents accepted:
  - O_DONE high exactly 2 cycles later.
  - O_EJECT never asserted, O_SHORT=0.
- COIN_INIT=1:
  - First request of 30 ejects 25 then 5; O_SHORT=0.
  - Second request of 30 ejects 10 then 1, then ends with O_SHORT=1, O_REMAIN=19.
- ACK_TIMEOUT=8, ack held low on a 100-cent request:
  - O_EJECT drops after 8 EJECT cycles and O_FAULT=1.
  - O_REQ_READY stays 0 until I_RESET.
- I_RESET asserted mid-EJECT:
  - Next cycle shows O_EJECT=0, O_REQ_READY=1, all counts=COIN_INIT.
- Hoppers depleted, then I_REFILL together with I_REQ_VALID=500 in IDLE:
  - Refill applies and 500 is ejected.
  - I_REFILL pulsed during EJECT has no effect on the counts.
